// File: rtl/hazard_ctrl_mc.sv
// Hazard unit for the 5-stage RISC-V pipeline: EX operand forwarding, load-use stall,
// taken-branch flush, multi-cycle MUL/DIV occupancy sequencer and a saturating stall counter.
module hazard_ctrl_mc #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE0,
  input  logic              PCSrcE,
  input  logic              MduStartE,
  input  logic              StallClr,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              MduBusy,
  output logic              MduDoneE,
  output logic [CNT_W-1:0]  StallCount
);

  localparam int MCW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
  localparam logic [MCW-1:0]    MDU_LAST = MCW'(MDU_LAT - 1);
  localparam logic [MCW-1:0]    MDU_ZERO = {MCW{1'b0}};
  localparam logic [MCW-1:0]    MDU_ONE  = MCW'(1);
  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

  logic [MCW-1:0]   mdu_cnt_r;
  logic [MCW-1:0]   mdu_cnt_nxt_s;
  logic             mdu_stall_s;
  logic             mdu_done_s;
  logic             lw_stall_s;
  logic             branch_s;
  logic             stall_f_s;
  logic [CNT_W-1:0] stall_cnt_r;

  // MEM result has priority over WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rd_m, input logic we_m,
                                         input logic [REG_AW-1:0] rd_w, input logic we_w);
    if (we_m && (rd_m != REG_ZERO) && (rd_m == rs)) begin
      return 2'b10;
    end else if (we_w && (rd_w != REG_ZERO) && (rd_w == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // MDU occupancy: start is only honoured from idle, so a held MduStartE cannot re-trigger.
  always_comb begin
    mdu_stall_s   = 1'b0;
    mdu_done_s    = 1'b0;
    mdu_cnt_nxt_s = mdu_cnt_r;
    if (MDU_LAT == 1) begin
      mdu_done_s    = MduStartE;
      mdu_cnt_nxt_s = MDU_ZERO;
    end else if (mdu_cnt_r == MDU_ZERO) begin
      mdu_stall_s   = MduStartE;
      mdu_cnt_nxt_s = MduStartE ? MDU_ONE : MDU_ZERO;
    end else if (mdu_cnt_r == MDU_LAST) begin
      mdu_done_s    = 1'b1;
      mdu_cnt_nxt_s = MDU_ZERO;
    end else begin
      mdu_stall_s   = 1'b1;
      mdu_cnt_nxt_s = mdu_cnt_r + MDU_ONE;
    end
  end

  // Load-use detection and branch qualification; the MDU stall masks both.
  always_comb begin
    lw_stall_s = ResultSrcE0 && (RdE != REG_ZERO) && ((RdE == Rs1D) || (RdE == Rs2D));
    branch_s   = PCSrcE && !mdu_stall_s;
    stall_f_s  = mdu_stall_s || (lw_stall_s && !PCSrcE);
  end

  // Control outputs, forced low while reset is asserted.
  always_comb begin
    ForwardAE  = 2'b00;
    ForwardBE  = 2'b00;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushM     = 1'b0;
    MduBusy    = 1'b0;
    MduDoneE   = 1'b0;
    StallCount = CNT_ZERO;
    if (rst) begin
      ForwardAE  = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE  = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      StallF     = stall_f_s;
      StallD     = stall_f_s;
      StallE     = mdu_stall_s;
      FlushD     = branch_s;
      FlushE     = branch_s || (lw_stall_s && !mdu_stall_s);
      FlushM     = mdu_stall_s;
      MduBusy    = mdu_stall_s;
      MduDoneE   = mdu_done_s;
      StallCount = stall_cnt_r;
    end else begin
      StallCount = CNT_ZERO;
    end
  end

  // MDU sequencer state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdu_cnt_r <= MDU_ZERO;
    end else begin
      mdu_cnt_r <= mdu_cnt_nxt_s;
    end
  end

  // Saturating stall-cycle counter; clear wins over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= CNT_ZERO;
    end else if (StallClr) begin
      stall_cnt_r <= CNT_ZERO;
    end else if (stall_f_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: three instances (default, MDU_LAT=1, CNT_W=3) share stimulus;
// directed scenarios use literal expectations, the random phase uses a cycle-level model.
module tb_hazard_ctrl_mc;

  logic clk, rst;
  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic rwm, rww, rse0, pcsrc, mdustart, stallclr;

  logic [1:0] fa_a, fb_a, fa_b, fb_b, fa_c, fb_c;
  logic sf_a, sd_a, se_a, fd_a, fe_a, fm_a, busy_a, done_a;
  logic sf_b, sd_b, se_b, fd_b, fe_b, fm_b, busy_b, done_b;
  logic sf_c, sd_c, se_c, fd_c, fe_c, fm_c, busy_c, done_c;
  logic [15:0] cnt_a, cnt_b;
  logic [2:0]  cnt_c;

  // Packed view: {FwdA[1:0], FwdB[1:0], StallF, StallD, StallE, FlushD, FlushE, FlushM, Busy, Done}
  wire [11:0] obs_a = {fa_a, fb_a, sf_a, sd_a, se_a, fd_a, fe_a, fm_a, busy_a, done_a};
  wire [11:0] obs_b = {fa_b, fb_b, sf_b, sd_b, se_b, fd_b, fe_b, fm_b, busy_b, done_b};
  wire [11:0] obs_c = {fa_c, fb_c, sf_c, sd_c, se_c, fd_c, fe_c, fm_c, busy_c, done_c};

  localparam logic [11:0] P_IDLE  = 12'h000;
  localparam logic [11:0] P_MDU   = {4'b0000, 8'b1110_0110};
  localparam logic [11:0] P_DONE  = {4'b0000, 8'b0000_0001};
  localparam logic [11:0] P_LWUSE = {4'b0000, 8'b1100_1000};
  localparam logic [11:0] P_BR    = {4'b0000, 8'b0001_1000};

  int total = 0;
  int bad   = 0;
  int age_m, cm_a, cm_b, cm_c;

  hazard_ctrl_mc #(.REG_AW(5), .MDU_LAT(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e),
    .RdE(rde), .RdM(rdm), .RdW(rdw), .RegWriteM(rwm), .RegWriteW(rww),
    .ResultSrcE0(rse0), .PCSrcE(pcsrc), .MduStartE(mdustart), .StallClr(stallclr),
    .ForwardAE(fa_a), .ForwardBE(fb_a), .StallF(sf_a), .StallD(sd_a), .StallE(se_a),
    .FlushD(fd_a), .FlushE(fe_a), .FlushM(fm_a), .MduBusy(busy_a), .MduDoneE(done_a),
    .StallCount(cnt_a));

  hazard_ctrl_mc #(.REG_AW(5), .MDU_LAT(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e),
    .RdE(rde), .RdM(rdm), .RdW(rdw), .RegWriteM(rwm), .RegWriteW(rww),
    .ResultSrcE0(rse0), .PCSrcE(pcsrc), .MduStartE(mdustart), .StallClr(stallclr),
    .ForwardAE(fa_b), .ForwardBE(fb_b), .StallF(sf_b), .StallD(sd_b), .StallE(se_b),
    .FlushD(fd_b), .FlushE(fe_b), .FlushM(fm_b), .MduBusy(busy_b), .MduDoneE(done_b),
    .StallCount(cnt_b));

  hazard_ctrl_mc #(.REG_AW(5), .MDU_LAT(4), .CNT_W(3)) dut_c (
    .clk(clk), .rst(rst), .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e),
    .RdE(rde), .RdM(rdm), .RdW(rdw), .RegWriteM(rwm), .RegWriteW(rww),
    .ResultSrcE0(rse0), .PCSrcE(pcsrc), .MduStartE(mdustart), .StallClr(stallclr),
    .ForwardAE(fa_c), .ForwardBE(fb_c), .StallF(sf_c), .StallD(sd_c), .StallE(se_c),
    .FlushD(fd_c), .FlushE(fe_c), .FlushM(fm_c), .MduBusy(busy_c), .MduDoneE(done_c),
    .StallCount(cnt_c));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic nxt;
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw} = '0;
    {rwm, rww, rse0, pcsrc, mdustart, stallclr} = '0;
  endtask

  // ---- reference model: cycles the MDU instruction has already spent in EX (-1 = none) ----
  function automatic int cur_age(input int lat, input int age);
    if (lat == 1) return -1;
    if (age >= 0) return age;
    return mdustart ? 0 : -1;
  endfunction

  function automatic int next_age(input int lat, input int age);
    int a;
    a = cur_age(lat, age);
    return (a >= 0 && a < lat - 1) ? a + 1 : -1;
  endfunction

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (rwm && rdm != 5'd0 && rdm == rs) return 2'b10;
    if (rww && rdw != 5'd0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [11:0] exp_ctrl(input int lat, input int age);
    int a;
    logic stall, done, lw;
    logic [7:0] c;
    a     = cur_age(lat, age);
    stall = (a >= 0) && (a < lat - 1);
    done  = (lat == 1) ? mdustart : (a == lat - 1);
    lw    = rse0 && rde != 5'd0 && (rde == rs1d || rde == rs2d);
    if (stall) c = 8'b1110_0110;
    else c = {lw && !pcsrc, lw && !pcsrc, 1'b0, pcsrc, pcsrc || lw, 1'b0, 1'b0, done};
    if (!rst) return 12'h000;
    return {fwd(rs1e), fwd(rs2e), c};
  endfunction

  task automatic test_reset;
    rwm = 1'b1; rdm = 5'd5; rs1e = 5'd5; mdustart = 1'b1; pcsrc = 1'b1;
    rse0 = 1'b1; rde = 5'd3; rs1d = 5'd3;
    #2;
    total++; if (obs_a !== P_IDLE) begin bad++; $display("FAIL reset_outs obs=%b exp=%b", obs_a, P_IDLE); end
    total++; if (obs_b !== P_IDLE) begin bad++; $display("FAIL reset_outs_lat1 obs=%b exp=%b", obs_b, P_IDLE); end
    @(posedge clk); #1;
    total++; if (cnt_a !== 16'd0 || obs_a !== P_IDLE) begin bad++; $display("FAIL reset_hold obs=%b cnt=%0d exp=0", obs_a, cnt_a); end
    nxt(); clear_inputs(); rst = 1'b1;
  endtask

  task automatic test_forward;
    rdm = 5'd5; rdw = 5'd5; rwm = 1'b1; rww = 1'b1; rs1e = 5'd5; rs2e = 5'd0;
    #2;
    total++; if ({fa_a, fb_a} !== 4'b1000) begin bad++; $display("FAIL fwd_mem got=%b want=1000", {fa_a, fb_a}); end
    rwm = 1'b0; #2;
    total++; if (fa_a !== 2'b01) begin bad++; $display("FAIL fwd_wb got=%b want=01", fa_a); end
    rwm = 1'b1; rdm = 5'd0; rs2e = 5'd0; rdw = 5'd0; #2;
    total++; if ({fa_a, fb_a} !== 4'b0000) begin bad++; $display("FAIL fwd_x0 got=%b want=0000", {fa_a, fb_a}); end
    nxt(); clear_inputs();
  endtask

  task automatic test_load_use;
    stallclr = 1'b1; nxt(); stallclr = 1'b0;
    rse0 = 1'b1; rde = 5'd7; rs2d = 5'd7; rs1d = 5'd1; #2;
    total++; if (obs_a !== P_LWUSE) begin bad++; $display("FAIL load_use obs=%b exp=%b", obs_a, P_LWUSE); end
    nxt();
    rse0 = 1'b0; rde = 5'd0; rs2d = 5'd0; rdm = 5'd7; rwm = 1'b1; rs2e = 5'd7; #2;
    total++; if (obs_a !== {2'b00, 2'b10, 8'h00}) begin bad++; $display("FAIL load_fwd obs=%b exp=%b", obs_a, {2'b00, 2'b10, 8'h00}); end
    total++; if (cnt_a !== 16'd1) begin bad++; $display("FAIL load_cnt got=%0d want=1", cnt_a); end
    nxt(); clear_inputs();
  endtask

  task automatic test_mdu;
    logic [11:0] e;
    stallclr = 1'b1; nxt(); stallclr = 1'b0;
    mdustart = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #2;
      e = (c < 4) ? P_MDU : P_DONE;
      total++; if (obs_a !== e) begin bad++; $display("FAIL mdu_cyc%0d obs=%b exp=%b", c, obs_a, e); end
      total++; if (obs_b !== P_DONE) begin bad++; $display("FAIL mdu_lat1_cyc%0d obs=%b exp=%b", c, obs_b, P_DONE); end
      nxt();
    end
    mdustart = 1'b0; #2;
    total++; if (obs_a !== P_IDLE) begin bad++; $display("FAIL mdu_after obs=%b exp=%b", obs_a, P_IDLE); end
    total++; if (cnt_a !== 16'd3) begin bad++; $display("FAIL mdu_cnt got=%0d want=3", cnt_a); end
    total++; if (cnt_b !== 16'd0) begin bad++; $display("FAIL mdu_lat1_cnt got=%0d want=0", cnt_b); end
    nxt();
  endtask

  task automatic test_conflicts;
    logic [11:0] e;
    rse0 = 1'b1; rde = 5'd3; rs1d = 5'd3; pcsrc = 1'b1; #2;
    total++; if (obs_a !== P_BR) begin bad++; $display("FAIL br_vs_lw obs=%b exp=%b", obs_a, P_BR); end
    nxt();
    mdustart = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #2;
      e = (c < 4) ? P_MDU : (P_BR | P_DONE);
      total++; if (obs_a !== e) begin bad++; $display("FAIL br_in_mdu_cyc%0d obs=%b exp=%b", c, obs_a, e); end
      nxt();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid;
    logic [11:0] e;
    mdustart = 1'b1;
    nxt(); nxt(); #2;
    total++; if (obs_a !== P_MDU) begin bad++; $display("FAIL mid_before obs=%b exp=%b", obs_a, P_MDU); end
    rst = 1'b0; #1;
    total++; if (obs_a !== P_IDLE || cnt_a !== 16'd0) begin bad++; $display("FAIL mid_async obs=%b cnt=%0d exp=0", obs_a, cnt_a); end
    nxt(); rst = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #2;
      e = (c < 4) ? P_MDU : P_DONE;
      total++; if (obs_a !== e) begin bad++; $display("FAIL mid_restart_cyc%0d obs=%b exp=%b", c, obs_a, e); end
      nxt();
    end
    mdustart = 1'b0; #2;
    total++; if (cnt_a !== 16'd3) begin bad++; $display("FAIL mid_cnt got=%0d want=3", cnt_a); end
    nxt();
  endtask

  task automatic test_counter;
    stallclr = 1'b1; nxt(); stallclr = 1'b0;
    rse0 = 1'b1; rde = 5'd2; rs1d = 5'd2;
    repeat (10) nxt();
    rse0 = 1'b0; #2;
    total++; if (cnt_c !== 3'd7) begin bad++; $display("FAIL cnt_sat got=%0d want=7", cnt_c); end
    total++; if (cnt_a !== 16'd10) begin bad++; $display("FAIL cnt_wide got=%0d want=10", cnt_a); end
    nxt();
    rse0 = 1'b1; stallclr = 1'b1; nxt();
    rse0 = 1'b0; stallclr = 1'b0; #2;
    total++; if (cnt_c !== 3'd0 || cnt_a !== 16'd0) begin bad++; $display("FAIL cnt_clr got=%0d/%0d want=0/0", cnt_c, cnt_a); end
    nxt(); clear_inputs();
  endtask

  task automatic test_random;
    logic [11:0] ea, eb;
    rst = 1'b0; nxt(); rst = 1'b1;
    age_m = -1; cm_a = 0; cm_b = 0; cm_c = 0;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) != 0);
      rs1d = 5'($urandom_range(0, 3)); rs2d = 5'($urandom_range(0, 3));
      rs1e = 5'($urandom_range(0, 3)); rs2e = 5'($urandom_range(0, 3));
      rde  = 5'($urandom_range(0, 3)); rdm  = 5'($urandom_range(0, 3));
      rdw  = 5'($urandom_range(0, 3));
      rwm = 1'($urandom_range(0, 1)); rww = 1'($urandom_range(0, 1));
      rse0 = 1'($urandom_range(0, 1));
      pcsrc = ($urandom_range(0, 5) == 0);
      mdustart = ($urandom_range(0, 2) == 0);
      stallclr = ($urandom_range(0, 19) == 0);
      #2;
      ea = exp_ctrl(4, age_m);
      eb = exp_ctrl(1, -1);
      total++; if (obs_a !== ea) begin bad++; $display("FAIL rnd%0d_a obs=%b exp=%b", i, obs_a, ea); end
      total++; if (obs_b !== eb) begin bad++; $display("FAIL rnd%0d_b obs=%b exp=%b", i, obs_b, eb); end
      total++; if (obs_c !== ea) begin bad++; $display("FAIL rnd%0d_c obs=%b exp=%b", i, obs_c, ea); end
      total++; if (cnt_a !== 16'(rst ? cm_a : 0) || cnt_b !== 16'(rst ? cm_b : 0) || cnt_c !== 3'(rst ? cm_c : 0)) begin
        bad++; $display("FAIL rnd%0d_cnt got=%0d/%0d/%0d want=%0d/%0d/%0d", i, cnt_a, cnt_b, cnt_c,
                        rst ? cm_a : 0, rst ? cm_b : 0, rst ? cm_c : 0);
      end
      if (!rst || stallclr) begin
        cm_a = 0; cm_b = 0; cm_c = 0;
      end else begin
        cm_a = (cm_a + int'(ea[7]) > 65535) ? 65535 : cm_a + int'(ea[7]);
        cm_b = (cm_b + int'(eb[7]) > 65535) ? 65535 : cm_b + int'(eb[7]);
        cm_c = (cm_c + int'(ea[7]) > 7) ? 7 : cm_c + int'(ea[7]);
      end
      age_m = rst ? next_age(4, age_m) : -1;
      nxt();
    end
    clear_inputs(); rst = 1'b1;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    clear_inputs();
    nxt();
    test_reset();
    test_forward();
    test_load_use();
    test_mdu();
    test_conflicts();
    test_reset_mid();
    test_counter();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
- Next-generation hazard unit for the 5-stage RISC-V pipeline.
- Keeps the EX-stage operand forwarding (MEM over WB priority). Adds load-use stall, taken-branch flush, and a multi-cycle MUL/DIV (MDU) occupancy sequencer that freezes F/D/E for a parametrised latency.
- Also provides a saturating stall-cycle performance counter.
- Sits beside the datapath; all control outputs feed the pipeline register enables/clears and the EX operand muxes.

Parameters:
- REG_AW, 5, register-address width (Rs/Rd fields).
- MDU_LAT, 4, total cycles a MUL/DIV instruction occupies EX (>=1).
- CNT_W, 16, width of stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous active-low reset.
- Rs1D, Rs2D  in  REG_AW  source regs of instruction in DECODE.
- Rs1E, Rs2E  in  REG_AW  source regs of instruction in EXECUTE.
- RdE, RdM, RdW  in  REG_AW  dest regs in EXECUTE/MEMORY/WRITEBACK.
- RegWriteM, RegWriteW  in  1  write-enable of MEM/WB instructions.
- ResultSrcE0  in  1  instruction in EX is a load.
- PCSrcE  in  1  branch/jump taken, resolved in EX.
- MduStartE  in  1  instruction in EX is MUL/DIV; held high while it sits in EX.
- StallClr  in  1  synchronous clear of StallCount.
- ForwardAE, ForwardBE  out  2  00 = regfile, 01 = WB result, 10 = MEM ALU result.
- StallF, StallD, StallE  out  1  hold PC / IF-ID / ID-EX registers.
- FlushD, FlushE, FlushM  out  1  clear IF-ID / ID-EX / EX-MEM registers (bubble).
- MduBusy  out  1  MDU sequence in progress.
- MduDoneE  out  1  final EX cycle of MDU instruction.
- StallCount  out  CNT_W  saturating count of cycles with StallF=1.

Behaviour:
- Reset:
  - rst=0 (async): mdu_cnt=0, StallCount=0.
  - While rst=0, all outputs are forced to 0 combinationally.
- Forwarding (combinational), per operand X in {1,2}:
  - 10 if RegWriteM & RdM!=0 & RdM==RsXE.
  - else 01 if RegWriteW & RdW!=0 & RdW==RsXE.
  - else 00.
  - Active in every cycle, including stalls.
- Load-use hazard:
  - lwStall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
  - Effect: StallF=StallD=1, FlushE=1, for one cycle per occurrence.
- Branch: PCSrcE=1 -> FlushD=1, FlushE=1.
- MDU sequencer (registered mdu_cnt, range 0..MDU_LAT-1):
  - Idle when mdu_cnt==0.
  - Idle & MduStartE & MDU_LAT>1: mdu_stall=1, mdu_cnt<=1.
  - mdu_cnt in 1..MDU_LAT-2: mdu_stall=1, mdu_cnt<=mdu_cnt+1.
  - mdu_cnt==MDU_LAT-1: mdu_stall=0, MduDoneE=1, mdu_cnt<=0.
  - MDU_LAT==1: MduDoneE=MduStartE in the same cycle, no stall, counter unused.
  - MduBusy = mdu_stall.
  - MduStartE is ignored while mdu_cnt!=0, so it is never re-triggered mid-sequence.
  - mdu_stall -> StallF=StallD=StallE=1, FlushM=1.
  - Net effect: the instruction spends exactly MDU_LAT cycles in EX, and MDU_LAT-1 bubbles enter MEM.
- Priority / simultaneity:
  - mdu_stall dominates. lwStall and PCSrcE are masked (FlushD=FlushE=0) while mdu_stall=1, and are evaluated normally in the MduDoneE cycle.
  - PCSrcE & lwStall: branch wins. FlushD=FlushE=1, StallF=StallD=0.
  - FlushE from lwStall and from the branch OR together when both apply.
- StallCount:
  - Increments each cycle StallF=1.
  - Saturates at 2^CNT_W-1 (no wrap).
  - StallClr=1 -> 0 next edge; clear has priority over increment.
- Reset mid-sequence: outputs drop to 0 immediately. After release the sequencer is idle; a still-high MduStartE restarts a full MDU_LAT sequence.

Test Plan:
- Forwarding: RdM=RdW=5, both RegWrite=1, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. Clear RegWriteM -> ForwardAE=01.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> one cycle with StallF=StallD=FlushE=1. Next cycle (load moved to MEM) -> all 0, ForwardBE=10 when Rs2E=7.
- MDU, MDU_LAT=4: MduStartE held 4 cycles -> StallF/D/E=FlushM=MduBusy=1 for cycles 1-3, MduDoneE=1 and stalls 0 in cycle 4, StallCount +3. Repeat with MDU_LAT=1 -> no stall, MduDoneE in the start cycle.
- Conflicts:
  - PCSrcE=1 together with lwStall -> FlushD=FlushE=1, StallF=0.
  - PCSrcE=1 during MDU busy -> masked, FlushD=0.
- Reset mid-MDU: rst low at mdu_cnt=2 -> all outputs 0 asynchronously. Release with MduStartE=1 -> full 3 stall cycles again.
- Counter: CNT_W=3, 10 continuous stall cycles -> StallCount saturates at 7. StallClr=1 together with a stall -> 0.
